ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It executes MULT, MULTU, DIV, DIVU, MTHI, MTLO and serves MFHI/MFLO reads from its architectural HI/LO registers. While a 32-cycle operation is in flight, it raises a stall request that the hazard logic routes to the ID/EX `Stall` input for any dependent or conflicting instruction.

---
 rtl/ex_muldiv_if.sv | 27 ++
 rtl/ex_muldiv.sv | 174 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Handshake-free bus between the EX stage and the iterative mul/div unit.
// The EX stage drives operation/operands; the unit returns busy, stall request and HI/LO.
interface ex_muldiv_if;
    logic [2:0]  md_op;
    logic [1:0]  md_rd;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        flush;
    logic        ex_hold;
    logic        busy;
    logic        stall_req;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    // Issue rule: an op is accepted on a rising edge when md_op is valid, busy is 0,
    // and neither flush nor ex_hold is set; otherwise stall_req tells the hazard logic to hold.
    modport master (
        output md_op, md_rd, md_a, md_b, flush, ex_hold,
        input  busy, stall_req, md_rdata, hi, lo, dbg_state
    );
    modport slave (
        input  md_op, md_rd, md_a, md_b, flush, ex_hold,
        output busy, stall_req, md_rdata, hi, lo, dbg_state
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-cycle multiply / restoring divide unit with architectural HI/LO.
// Signed ops run on magnitudes; the sign is reapplied in the FIX state.
module ex_muldiv (
    input  logic         clk,
    input  logic         rst,
    ex_muldiv_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] opnd_q, opnd_d;   // |a| for multiply, |b| for divide
    logic [31:0] acc_q, acc_d;     // P[63:32] for multiply, R for divide
    logic [31:0] low_q, low_d;     // P[31:0] for multiply, Q for divide
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;

    logic        op_valid, rd_valid, issue, is_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] r_sh;
    logic [31:0] diff;
    logic        trial_ge;
    logic [63:0] prod, prod_fix;

    always_comb begin
        op_valid  = (bus.md_op != 3'd0) && (bus.md_op != 3'd7);
        rd_valid  = (bus.md_rd == 2'b01) || (bus.md_rd == 2'b10);
        issue     = op_valid && !busy_q && !bus.flush && !bus.ex_hold;
        is_signed = (bus.md_op == OP_MULT) || (bus.md_op == OP_DIV);
        a_neg     = is_signed && bus.md_a[31];
        b_neg     = is_signed && bus.md_b[31];
        a_mag     = a_neg ? (32'd0 - bus.md_a) : bus.md_a;
        b_mag     = b_neg ? (32'd0 - bus.md_b) : bus.md_b;

        mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : 33'd0);
        // R stays below |b| after each step, so 32 bits of R plus the shifted-in bit suffice
        r_sh      = {acc_q, low_q[31]};
        trial_ge  = r_sh >= {1'b0, opnd_q};
        diff      = r_sh[31:0] - opnd_q;
        prod      = {acc_q, low_q};
        prod_fix  = neg_q ? (64'd0 - prod) : prod;

        state_d   = state_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        low_d     = low_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    case (bus.md_op)
                        OP_MTHI: hi_d = bus.md_a;
                        OP_MTLO: lo_d = bus.md_a;
                        OP_MULT, OP_MULTU: begin
                            is_div_d  = 1'b0;
                            neg_d     = a_neg ^ b_neg;
                            rem_neg_d = 1'b0;
                            opnd_d    = a_mag;
                            acc_d     = 32'd0;
                            low_d     = b_mag;
                            cnt_d     = 5'd0;
                            state_d   = S_CALC;
                        end
                        OP_DIV, OP_DIVU: begin
                            is_div_d = 1'b1;
                            cnt_d    = 5'd0;
                            if (bus.md_b == 32'd0) begin
                                // divide by zero: preload the final values, FIX copies them unsigned
                                neg_d     = 1'b0;
                                rem_neg_d = 1'b0;
                                acc_d     = bus.md_a;
                                low_d     = 32'hFFFF_FFFF;
                                state_d   = S_FIX;
                            end else begin
                                neg_d     = a_neg ^ b_neg;
                                rem_neg_d = a_neg;
                                opnd_d    = b_mag;
                                acc_d     = 32'd0;
                                low_d     = a_mag;
                                state_d   = S_CALC;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    acc_d = trial_ge ? diff : r_sh[31:0];
                    low_d = {low_q[30:0], trial_ge};
                end else begin
                    acc_d = mul_sum[32:1];
                    low_d = {mul_sum[0], low_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_q ? (32'd0 - low_q) : low_q;
                    hi_d = rem_neg_q ? (32'd0 - acc_q) : acc_q;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                cnt_d   = 5'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            opnd_q    <= 32'd0;
            acc_q     <= 32'd0;
            low_q     <= 32'd0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            low_q     <= low_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.stall_req = busy_q && (op_valid || rd_valid);
    assign bus.md_rdata  = (bus.md_rd == 2'b01) ? hi_q :
                           (bus.md_rd == 2'b10) ? lo_q : 32'd0;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed vectors, an arithmetic reference model checked every
// cycle, and literal expectations for the documented corner cases.
module tb_ex_muldiv;
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ex_muldiv_if bus ();

    ex_muldiv dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_left = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;

    // {HI, LO} from plain arithmetic
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = 64'd0;
        case (op)
            OP_MULT:  r = sa * sb;
            OP_MULTU: r = ua * ub;
            OP_DIV:   r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            OP_DIVU:  r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
            default:  r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic logic op_ok(input logic [2:0] op);
        return (op != 3'd0) && (op != 3'd7);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [63:0] r;
        if (!rst_n) begin
            m_left <= 0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (op_ok(bus.md_op) && !bus.flush && !bus.ex_hold) begin
            case (bus.md_op)
                OP_MTHI: m_hi <= bus.md_a;
                OP_MTLO: m_lo <= bus.md_a;
                default: begin
                    r      = ref_result(bus.md_op, bus.md_a, bus.md_b);
                    p_hi   <= r[63:32];
                    p_lo   <= r[31:0];
                    m_left <= ((bus.md_op == OP_DIV || bus.md_op == OP_DIVU) && bus.md_b == 32'd0) ? 1 : 33;
                end
            endcase
        end
    end

    // ---------------- checking ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic        e_busy, e_stall;
        logic [31:0] e_rdata;
        e_busy  = (m_left != 0);
        e_stall = e_busy && (op_ok(bus.md_op) || bus.md_rd == 2'b01 || bus.md_rd == 2'b10);
        e_rdata = (bus.md_rd == 2'b01) ? m_hi : (bus.md_rd == 2'b10) ? m_lo : 32'd0;
        check32("cyc_busy", {31'd0, bus.busy}, {31'd0, e_busy});
        check32("cyc_stall", {31'd0, bus.stall_req}, {31'd0, e_stall});
        check32("cyc_rdata", bus.md_rdata, e_rdata);
        check32("cyc_hi", bus.hi, m_hi);
        check32("cyc_lo", bus.lo, m_lo);
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic [2:0] op, input logic [1:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input logic fl, input logic hd);
        bus.md_op   = op;
        bus.md_rd   = rd;
        bus.md_a    = a;
        bus.md_b    = b;
        bus.flush   = fl;
        bus.ex_hold = hd;
    endtask

    task automatic drive(input logic [2:0] op, input logic [1:0] rd, input logic [31:0] a,
                         input logic [31:0] b, input logic fl, input logic hd);
        set_in(op, rd, a, b, fl, hd);
        @(posedge clk);
        #1;
    endtask

    // which: 0 counts busy cycles, 1 counts stall_req cycles; inputs are left as set
    task automatic count_while(input int which, output int n);
        n = 0;
        while ((((which == 0) ? bus.busy : bus.stall_req) === 1'b1) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL timeout: signal %0d still high after %0d cycles", which, n);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        drive(op, 2'b00, a, b, 1'b0, 1'b0);
        set_in(OP_NONE, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
        count_while(0, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [2:0]  v_op [8] = '{OP_MULT, OP_MULT, OP_MULTU, OP_DIV, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU};
    logic [31:0] v_a  [8] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd100,
                              32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'hFFFF_FFF6, 32'd3};
    logic [31:0] v_b  [8] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd3, 32'd0, 32'h8000_0000};

    initial begin
        int n;
        set_in(OP_NONE, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        check32("reset_busy", {31'd0, bus.busy}, 32'd0);
        check32("reset_hi", bus.hi, 32'd0);
        check32("reset_lo", bus.lo, 32'd0);
        check32("reset_stall", {31'd0, bus.stall_req}, 32'd0);
        check32("reset_rdata", bus.md_rdata, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, n);
        check32("mult_busy_cycles", n, 33);
        check32("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check32("mult_lo", bus.lo, 32'hFFFF_FFFE);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, n);
        check32("multu_hi", bus.hi, 32'h0000_0001);
        check32("multu_lo", bus.lo, 32'hFFFF_FFFE);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
        check32("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
        check32("div_neg_hi", bus.hi, 32'hFFFF_FFFF);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        check32("div_ovf_lo", bus.lo, 32'h8000_0000);
        check32("div_ovf_hi", bus.hi, 32'd0);

        run_op(OP_DIVU, 32'd7, 32'd0, n);
        check32("divz_busy_cycles", n, 1);
        check32("divz_lo", bus.lo, 32'hFFFF_FFFF);
        check32("divz_hi", bus.hi, 32'd7);

        // dependent MFLO behind a multiply
        drive(OP_MULT, 2'b00, 32'd3, 32'd5, 1'b0, 1'b0);
        set_in(OP_NONE, 2'b10, 32'd0, 32'd0, 1'b0, 1'b0);
        count_while(1, n);
        check32("mflo_stall_cycles", n, 33);
        check32("mflo_rdata", bus.md_rdata, 32'd15);
        set_in(OP_NONE, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);

        drive(OP_MULT, 2'b00, 32'd9, 32'd9, 1'b1, 1'b0);
        check32("flush_no_issue", {31'd0, bus.busy}, 32'd0);
        drive(OP_MULT, 2'b00, 32'd9, 32'd9, 1'b0, 1'b1);
        check32("hold_no_issue", {31'd0, bus.busy}, 32'd0);

        drive(OP_MTHI, 2'b00, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        set_in(OP_NONE, 2'b01, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        check32("mfhi_stall", {31'd0, bus.stall_req}, 32'd0);
        check32("mfhi_rdata", bus.md_rdata, 32'h1234_5678);

        // MTLO waiting behind a multiply
        drive(OP_MULT, 2'b00, 32'd2, 32'd3, 1'b0, 1'b0);
        set_in(OP_MTLO, 2'b00, 32'hAAAA_5555, 32'd0, 1'b0, 1'b0);
        #1;
        check32("mtlo_stall", {31'd0, bus.stall_req}, 32'd1);
        count_while(0, n);
        check32("mtlo_after_mult_lo", bus.lo, 32'd6);
        @(posedge clk);
        #1;
        check32("mtlo_written", bus.lo, 32'hAAAA_5555);
        set_in(OP_NONE, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);

        // back-to-back vectors, checked against the model every cycle
        for (int i = 0; i < 8; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], n);
        end
        check32("vec_divz_signed_hi", bus.hi, 32'd3);
        check32("vec_divu_big_lo", bus.lo, 32'd0);

        // reset in the middle of a multiply
        drive(OP_MULT, 2'b00, 32'd5, 32'd7, 1'b0, 1'b0);
        set_in(OP_NONE, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check32("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check32("midrst_hi", bus.hi, 32'd0);
        check32("midrst_lo", bus.lo, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check32("midrst_late_hi", bus.hi, 32'd0);
        check32("midrst_late_lo", bus.lo, 32'd0);
        check32("midrst_late_busy", {31'd0, bus.busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
